// File: rtl/port_link_dev.sv
// -----------------------------------------------------------------------------
// port_link_dev
//
// Pin-side peripheral for a 4-phase strobe/acknowledge nibble link. The CPU
// drives STB and DIR on the control pins and, for writes, the data pins. CPU
// writes land in an RX FIFO for a local consumer. Nibbles a local producer
// pushes into a TX FIFO are returned to the CPU on read transactions.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset (synchronous release)
//   pin_ctl   [0] STB in, [1] ACK out, [2] DIR in (0 = write, 1 = read), [3] RDY out
//   pin_data  nibble bus; driven by the device only from read setup to read ack exit
//   rx_data   head of RX FIFO (0 while empty)
//   rx_valid  RX FIFO not empty
//   rx_ready  local consumer pop, effective when rx_valid = 1
//   tx_data   nibble from local producer
//   tx_valid  producer push request, accepted when the TX FIFO has room
//   tx_ready  TX FIFO not full
//   rx_level  RX FIFO occupancy
//   tx_level  TX FIFO occupancy
// -----------------------------------------------------------------------------
module port_link_dev #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    inout  wire  [3:0]    pin_ctl,
    inout  wire  [3:0]    pin_data,
    output logic [3:0]    rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    input  logic [3:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [AW:0]   rx_level,
    output logic [AW:0]   tx_level
);

    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LVL_ZERO = (AW + 1)'(0);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_ACK   = 2'd1,
        RD_SETUP = 2'd2,
        RD_ACK   = 2'd3
    } state_t;

    state_t      state_r;
    logic        ack_r;
    logic        rdy_r;
    logic        drive_r;
    logic [3:0]  dout_r;

    logic [1:0]  stb_sync_r;
    logic [1:0]  dir_sync_r;
    logic [3:0]  dat_meta_r;
    logic [3:0]  dat_sync_r;
    logic        stb_s;
    logic        dir_s;
    logic [3:0]  dat_s;

    logic [3:0]    rx_mem_r [DEPTH];
    logic [AW-1:0] rx_wr_ptr_r;
    logic [AW-1:0] rx_rd_ptr_r;
    logic [AW:0]   rx_count_r;
    logic [AW:0]   rx_count_nxt_s;
    logic          rx_valid_r;

    logic [3:0]    tx_mem_r [DEPTH];
    logic [AW-1:0] tx_wr_ptr_r;
    logic [AW-1:0] tx_rd_ptr_r;
    logic [AW:0]   tx_count_r;
    logic [AW:0]   tx_count_nxt_s;
    logic          tx_ready_r;

    logic rx_push_s;
    logic rx_pop_s;
    logic tx_push_s;
    logic tx_pop_s;
    logic rd_start_s;

    // STB, DIR and the data pins are CPU-driven; only ACK and RDY are driven
    // here, and the data bus only while a read is being answered.
    assign pin_ctl[1] = ack_r;
    assign pin_ctl[3] = rdy_r;
    assign pin_data   = drive_r ? dout_r : 4'bzzzz;

    assign stb_s = stb_sync_r[1];
    assign dir_s = dir_sync_r[1];
    assign dat_s = dat_sync_r;

    assign rx_data  = rx_valid_r ? rx_mem_r[rx_rd_ptr_r] : 4'h0;
    assign rx_valid = rx_valid_r;
    assign tx_ready = tx_ready_r;
    assign rx_level = rx_count_r;
    assign tx_level = tx_count_r;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign rx_pop_s   = rx_ready && (rx_count_r != LVL_ZERO);
    assign rx_push_s  = (state_r == IDLE) && stb_s && !dir_s &&
                        ((rx_count_r != LVL_FULL) || rx_pop_s);
    assign tx_pop_s   = (state_r == RD_ACK) && !stb_s;
    assign tx_push_s  = tx_valid && ((tx_count_r != LVL_FULL) || tx_pop_s);
    assign rd_start_s = (state_r == IDLE) && stb_s && dir_s && (tx_count_r != LVL_ZERO);

    // Two-flop synchronisers for the CPU-driven pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_sync_r <= 2'b00;
            dir_sync_r <= 2'b00;
            dat_meta_r <= 4'h0;
            dat_sync_r <= 4'h0;
        end else begin
            stb_sync_r <= {stb_sync_r[0], pin_ctl[0]};
            dir_sync_r <= {dir_sync_r[0], pin_ctl[2]};
            dat_meta_r <= pin_data;
            dat_sync_r <= dat_meta_r;
        end
    end

    // Next occupancy of both FIFOs; push and pop together leave it unchanged.
    always_comb begin
        rx_count_nxt_s = rx_count_r;
        tx_count_nxt_s = tx_count_r;
        if (rx_push_s && !rx_pop_s) begin
            rx_count_nxt_s = rx_count_r + LVL_ONE;
        end else if (!rx_push_s && rx_pop_s) begin
            rx_count_nxt_s = rx_count_r - LVL_ONE;
        end else begin
            rx_count_nxt_s = rx_count_r;
        end
        if (tx_push_s && !tx_pop_s) begin
            tx_count_nxt_s = tx_count_r + LVL_ONE;
        end else if (!tx_push_s && tx_pop_s) begin
            tx_count_nxt_s = tx_count_r - LVL_ONE;
        end else begin
            tx_count_nxt_s = tx_count_r;
        end
    end

    // RX FIFO: filled by CPU writes, drained by the local consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rx_mem_r[i] <= 4'h0;
            end
            rx_wr_ptr_r <= '0;
            rx_rd_ptr_r <= '0;
            rx_count_r  <= LVL_ZERO;
            rx_valid_r  <= 1'b0;
        end else begin
            if (rx_push_s) begin
                rx_mem_r[rx_wr_ptr_r] <= dat_s;
                rx_wr_ptr_r           <= rx_wr_ptr_r + PTR_ONE;
            end
            if (rx_pop_s) begin
                rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
            end
            rx_count_r <= rx_count_nxt_s;
            rx_valid_r <= (rx_count_nxt_s != LVL_ZERO);
        end
    end

    // TX FIFO: filled by the local producer, drained when a CPU read completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tx_mem_r[i] <= 4'h0;
            end
            tx_wr_ptr_r <= '0;
            tx_rd_ptr_r <= '0;
            tx_count_r  <= LVL_ZERO;
            tx_ready_r  <= 1'b1;
        end else begin
            if (tx_push_s) begin
                tx_mem_r[tx_wr_ptr_r] <= tx_data;
                tx_wr_ptr_r           <= tx_wr_ptr_r + PTR_ONE;
            end
            if (tx_pop_s) begin
                tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
            end
            tx_count_r <= tx_count_nxt_s;
            tx_ready_r <= (tx_count_nxt_s != LVL_FULL);
        end
    end

    // Handshake FSM with registered ACK, RDY and data-bus drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ack_r   <= 1'b0;
            rdy_r   <= 1'b0;
            drive_r <= 1'b0;
            dout_r  <= 4'h0;
        end else begin
            // RDY trails the TX level by one cycle.
            rdy_r <= (tx_count_r != LVL_ZERO);
            case (state_r)
                IDLE: begin
                    // A write with RX full, or a read with TX empty, stalls here.
                    if (rx_push_s) begin
                        state_r <= WR_ACK;
                        ack_r   <= 1'b1;
                    end else if (rd_start_s) begin
                        // Drive data one cycle ahead of ACK for setup time.
                        state_r <= RD_SETUP;
                        drive_r <= 1'b1;
                        dout_r  <= tx_mem_r[tx_rd_ptr_r];
                    end
                end
                WR_ACK: begin
                    if (!stb_s) begin
                        state_r <= IDLE;
                        ack_r   <= 1'b0;
                    end
                end
                RD_SETUP: begin
                    state_r <= RD_ACK;
                    ack_r   <= 1'b1;
                end
                RD_ACK: begin
                    // The driven entry is popped on this same edge (tx_pop_s).
                    if (!stb_s) begin
                        state_r <= IDLE;
                        ack_r   <= 1'b0;
                        drive_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ack_r   <= 1'b0;
                    drive_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_port_link_dev.sv
// -----------------------------------------------------------------------------
// tb_port_link_dev
//
// Self-checking bench for port_link_dev. A CPU model drives STB/DIR/data on
// the pins, a local producer/consumer drives the FIFO side. Expected nibbles
// are queued when stimulus is applied (rx_exp for CPU writes, tx_exp for local
// pushes) and popped when the device presents them. The data bus is a tri1
// net, so a released bus reads back as 4'hF.
// -----------------------------------------------------------------------------
module tb_port_link_dev;

    logic        clk;
    logic        rst_n;
    logic        stb;
    logic        dir;
    logic        cpu_drv;
    logic [3:0]  cpu_dat;
    logic        rx_ready;
    logic [3:0]  tx_data;
    logic        tx_valid;
    logic [3:0]  rx_data;
    logic        rx_valid;
    logic        tx_ready;
    logic [3:0]  rx_level;
    logic [3:0]  tx_level;

    wire  [3:0]  pin_ctl;
    tri1  [3:0]  pin_data;
    wire         ack;
    wire         rdy;

    int          n_checks;
    int          n_fail;
    logic [3:0]  rx_exp [$];
    logic [3:0]  tx_exp [$];

    assign pin_ctl[0] = stb;
    assign pin_ctl[2] = dir;
    assign pin_data   = cpu_drv ? cpu_dat : 4'bzzzz;
    assign ack        = pin_ctl[1];
    assign rdy        = pin_ctl[3];

    port_link_dev #(.DEPTH(8), .AW(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pin_ctl  (pin_ctl),
        .pin_data (pin_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_level (rx_level),
        .tx_level (tx_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Full CPU write: DIR/data setup, STB up, wait ACK, STB down, wait ACK low.
    task automatic cpu_write(input logic [3:0] d);
        dir = 1'b0; cpu_dat = d; cpu_drv = 1'b1;
        repeat (2) @(negedge clk);
        stb = 1'b1;
        for (int i = 0; i < 20 && ack !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack_rise: got %b expected 1", ack); end
        rx_exp.push_back(d);
        stb = 1'b0;
        for (int i = 0; i < 20 && ack !== 1'b0; i++) @(negedge clk);
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_fall: got %b expected 0", ack); end
    endtask

    // Full CPU read, checking the returned nibble against the TX scoreboard.
    task automatic cpu_read();
        logic [3:0] e;
        dir = 1'b1; cpu_drv = 1'b0;
        repeat (2) @(negedge clk);
        stb = 1'b1;
        for (int i = 0; i < 20 && ack !== 1'b1; i++) @(negedge clk);
        e = tx_exp.pop_front();
        n_checks++;
        if (ack !== 1'b1 || pin_data !== e) begin
            n_fail++; $display("FAIL rd_data: got ack=%b data=%h expected ack=1 data=%h", ack, pin_data, e);
        end
        stb = 1'b0;
        for (int i = 0; i < 20 && ack !== 1'b0; i++) @(negedge clk);
        n_checks++;
        if (ack !== 1'b0 || pin_data !== 4'hF) begin
            n_fail++; $display("FAIL rd_release: got ack=%b data=%h expected ack=0 data=f", ack, pin_data);
        end
    endtask

    // One local producer push (caller ensures tx_ready).
    task automatic tx_push(input logic [3:0] d);
        tx_data = d; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_exp.push_back(d);
    endtask

    // One local consumer pop, checking the head against the RX scoreboard.
    task automatic rx_pop();
        logic [3:0] e;
        e = rx_exp.pop_front();
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== e) begin
            n_fail++; $display("FAIL rx_pop: got valid=%b data=%h expected valid=1 data=%h", rx_valid, rx_data, e);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stb = 1'b1; dir = 1'b0; cpu_drv = 1'b0; cpu_dat = 4'h0;
        rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 4'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ack !== 1'b0 || rdy !== 1'b0) begin n_fail++; $display("FAIL reset_ctl: got ack=%b rdy=%b expected 0 0", ack, rdy); end
        n_checks++;
        if (pin_data !== 4'hF) begin n_fail++; $display("FAIL reset_bus: got %h expected f", pin_data); end
        n_checks++;
        if (rx_valid !== 1'b0 || tx_ready !== 1'b1 || rx_data !== 4'h0) begin
            n_fail++; $display("FAIL reset_fifo: got rx_valid=%b tx_ready=%b rx_data=%h expected 0 1 0", rx_valid, tx_ready, rx_data);
        end
        n_checks++;
        if (rx_level !== 4'd0 || tx_level !== 4'd0) begin
            n_fail++; $display("FAIL reset_levels: got %0d %0d expected 0 0", rx_level, tx_level);
        end
        stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write();
        dir = 1'b0; cpu_dat = 4'hA; cpu_drv = 1'b1;
        repeat (2) @(negedge clk);
        stb = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_latency_early: got ack=%b expected 0", ack); end
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL wr_latency: got ack=%b expected 1", ack); end
        rx_exp.push_back(4'hA);
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 4'hA || rx_level !== 4'd1) begin
            n_fail++; $display("FAIL wr_rx: got valid=%b data=%h level=%0d expected 1 a 1", rx_valid, rx_data, rx_level);
        end
        stb = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL wr_drop_early: got ack=%b expected 1", ack); end
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_drop: got ack=%b expected 0", ack); end
        rx_pop();
        n_checks++;
        if (rx_valid !== 1'b0 || rx_level !== 4'd0) begin
            n_fail++; $display("FAIL wr_drain: got valid=%b level=%0d expected 0 0", rx_valid, rx_level);
        end
    endtask

    task automatic test_read();
        tx_push(4'h5);
        tx_push(4'hC);
        @(negedge clk);
        n_checks++;
        if (rdy !== 1'b1 || tx_level !== 4'd2) begin
            n_fail++; $display("FAIL rd_rdy: got rdy=%b level=%0d expected 1 2", rdy, tx_level);
        end
        dir = 1'b1; cpu_drv = 1'b0;
        repeat (2) @(negedge clk);
        stb = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (pin_data !== 4'hF || ack !== 1'b0) begin
            n_fail++; $display("FAIL rd_early: got data=%h ack=%b expected f 0", pin_data, ack);
        end
        @(negedge clk);
        n_checks++;
        if (pin_data !== tx_exp[0] || ack !== 1'b0) begin
            n_fail++; $display("FAIL rd_setup: got data=%h ack=%b expected %h 0", pin_data, ack, tx_exp[0]);
        end
        @(negedge clk);
        n_checks++;
        if (pin_data !== tx_exp[0] || ack !== 1'b1) begin
            n_fail++; $display("FAIL rd_ack: got data=%h ack=%b expected %h 1", pin_data, ack, tx_exp[0]);
        end
        void'(tx_exp.pop_front());
        stb = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (pin_data !== 4'hF || ack !== 1'b0 || tx_level !== 4'd1) begin
            n_fail++; $display("FAIL rd_exit: got data=%h ack=%b level=%0d expected f 0 1", pin_data, ack, tx_level);
        end
        cpu_read();
        @(negedge clk);
        n_checks++;
        if (rdy !== 1'b0 || tx_level !== 4'd0) begin
            n_fail++; $display("FAIL rd_empty: got rdy=%b level=%0d expected 0 0", rdy, tx_level);
        end
    endtask

    task automatic test_rx_full();
        for (int i = 1; i <= 8; i++) cpu_write(4'(i));
        n_checks++;
        if (rx_level !== 4'd8) begin n_fail++; $display("FAIL full_level: got %0d expected 8", rx_level); end
        dir = 1'b0; cpu_dat = 4'h9; cpu_drv = 1'b1;
        repeat (2) @(negedge clk);
        stb = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (ack !== 1'b0 || rx_level !== 4'd8) begin
            n_fail++; $display("FAIL full_stall: got ack=%b level=%0d expected 0 8", ack, rx_level);
        end
        rx_pop();
        for (int i = 0; i < 1 && ack !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL full_resume: got ack=%b expected 1", ack); end
        rx_exp.push_back(4'h9);
        stb = 1'b0;
        for (int i = 0; i < 20 && ack !== 1'b0; i++) @(negedge clk);
        n_checks++;
        if (rx_level !== 4'd8) begin n_fail++; $display("FAIL full_refill: got %0d expected 8", rx_level); end
        while (rx_exp.size() > 0) rx_pop();
    endtask

    task automatic test_read_stall();
        dir = 1'b1; cpu_drv = 1'b0;
        repeat (2) @(negedge clk);
        stb = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (ack !== 1'b0 || pin_data !== 4'hF || rdy !== 1'b0) begin
            n_fail++; $display("FAIL stall_idle: got ack=%b data=%h rdy=%b expected 0 f 0", ack, pin_data, rdy);
        end
        tx_push(4'h3);
        for (int i = 0; i < 10 && pin_data === 4'hF; i++) @(negedge clk);
        n_checks++;
        if (pin_data !== tx_exp[0] || ack !== 1'b0) begin
            n_fail++; $display("FAIL stall_data: got data=%h ack=%b expected %h 0", pin_data, ack, tx_exp[0]);
        end
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL stall_ack: got %b expected 1", ack); end
        void'(tx_exp.pop_front());
        stb = 1'b0;
        for (int i = 0; i < 20 && ack !== 1'b0; i++) @(negedge clk);
        n_checks++;
        if (ack !== 1'b0 || pin_data !== 4'hF) begin
            n_fail++; $display("FAIL stall_exit: got ack=%b data=%h expected 0 f", ack, pin_data);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) cpu_write(4'hB - 4'(i));
        dir = 1'b0; cpu_dat = 4'hE; cpu_drv = 1'b1;
        repeat (2) @(negedge clk);
        stb = 1'b1;
        repeat (2) @(negedge clk);
        // The link push lands on the next edge; pop on the same edge.
        rx_pop();
        rx_exp.push_back(4'hE);
        n_checks++;
        if (ack !== 1'b1 || rx_level !== 4'd4) begin
            n_fail++; $display("FAIL simul_level: got ack=%b level=%0d expected 1 4", ack, rx_level);
        end
        stb = 1'b0;
        for (int i = 0; i < 20 && ack !== 1'b0; i++) @(negedge clk);
        while (rx_exp.size() > 0) rx_pop();
    endtask

    task automatic test_abort();
        tx_push(4'h6);
        tx_push(4'h9);
        dir = 1'b1; cpu_drv = 1'b0;
        repeat (2) @(negedge clk);
        stb = 1'b1;
        for (int i = 0; i < 20 && ack !== 1'b1; i++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ack !== 1'b0 || pin_data !== 4'hF) begin
            n_fail++; $display("FAIL abort_async: got ack=%b data=%h expected 0 f", ack, pin_data);
        end
        n_checks++;
        if (tx_level !== 4'd0 || rx_level !== 4'd0 || tx_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_fifo: got tx=%0d rx=%0d ready=%b expected 0 0 1", tx_level, rx_level, tx_ready);
        end
        tx_exp.delete();
        stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ack !== 1'b0 || rx_valid !== 1'b0 || tx_level !== 4'd0 || rdy !== 1'b0) begin
            n_fail++; $display("FAIL abort_after: got ack=%b rx_valid=%b tx=%0d rdy=%b expected 0 0 0 0", ack, rx_valid, tx_level, rdy);
        end
        cpu_write(4'h7);
        rx_pop();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_write();
        test_read();
        test_rx_full();
        test_read_stall();
        test_simultaneous();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/port_link_dev.md
Name: port_link_dev

Overview:
- Peripheral that sits on the pin side of the CPU's 4-bit general-purpose I/O ports, at the far end of the port interface.
- Implements a 4-phase strobe/acknowledge nibble link over two 4-bit pin groups: a control group (wired to CPU port 7) and a data group (wired to CPU port 8).
- Nibbles the CPU writes go into an RX FIFO for a local consumer.
- Nibbles a local producer pushes into a TX FIFO are returned to the CPU on read transactions.

Parameters:
- DEPTH, 8, entries per FIFO; power of 2, minimum 2.
- AW, 3, pointer width = log2(DEPTH).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- pin_ctl  inout  4  control pins:
  - [0] STB, CPU-driven, device input
  - [1] ACK, device-driven
  - [2] DIR, CPU-driven, device input; 0 = CPU write, 1 = CPU read
  - [3] RDY, device-driven
- pin_data  inout  4  data pins; device drives only during a read acknowledge
- rx_data  output  4  head of RX FIFO
- rx_valid  output  1  RX FIFO not empty
- rx_ready  input  1  local consumer pop; effective when rx_valid=1
- tx_data  input  4  nibble from local producer
- tx_valid  input  1  producer push request
- tx_ready  output  1  TX FIFO not full
- rx_level  output  AW+1  RX FIFO occupancy
- tx_level  output  AW+1  TX FIFO occupancy

Behaviour:
- Single clock domain. Reset is asynchronous on rst_n falling, synchronous release.
- Reset values:
  - state IDLE
  - ACK=0, RDY=0
  - pin_data released (all z); pin_ctl[0] and [2] always z
  - both FIFOs empty, levels 0, rx_valid=0, tx_ready=1, rx_data=0
- Synchronisation:
  - STB, DIR and pin_data pass through 2-flop synchronisers; the FSM uses only the synchronised copies (stb_s, dir_s, dat_s).
  - The CPU sets DIR and data at least one port write before raising STB.
- RDY = registered (tx_level != 0); it updates one cycle after a level change.
- FSM states: IDLE, WR_ACK, RD_SETUP, RD_ACK.
  - IDLE -> WR_ACK: stb_s=1, dir_s=0, RX not full. Push dat_s into RX in that same cycle; ACK=1 from the next cycle.
  - IDLE stays IDLE: stb_s=1, dir_s=0, RX full. ACK withheld (stall) until space appears; no data is lost.
  - IDLE -> RD_SETUP: stb_s=1, dir_s=1, TX not empty. Drive the TX head onto pin_data; ACK still 0. This gives one cycle of data setup.
  - IDLE stays IDLE: stb_s=1, dir_s=1, TX empty. Stall; RDY=0 tells the CPU why.
  - RD_SETUP -> RD_ACK unconditionally; ACK=1, data held.
  - WR_ACK -> IDLE: when stb_s=0; ACK=0.
  - RD_ACK -> IDLE: when stb_s=0. Pop TX, release pin_data, ACK=0, all in the same edge.
  - DIR changes while STB is high are ignored until return to IDLE.
- Latency:
  - write: STB pin rise to ACK = 3 clk (2 sync + 1).
  - read: STB pin rise to data valid = 3 clk; to ACK = 4 clk.
- FIFOs: circular buffers with AW-bit pointers that wrap at DEPTH, and an AW+1-bit count.
  - Simultaneous push and pop on one FIFO: both take effect, level unchanged. This applies even when full (pop frees the slot) or when empty for RX local pop with link push (no pop, since rx_valid=0).
  - Local pop when empty and local push when full are ignored.
  - The TX entry being driven is not popped until RD_ACK exit. A local push to TX during a read is accepted if not full.
- Reset mid-transaction:
  - ACK drops and the bus releases immediately (asynchronous).
  - The FIFO contents are lost.
  - The CPU must restart from STB=0.

Test Plan:
- Reset: hold rst_n=0 with STB=1 -> ACK=0, RDY=0, pin_data=zzzz, rx_valid=0, tx_ready=1, levels 0.
- CPU write 4'hA:
  - DIR=0, data=A, then raise STB -> ACK=1 three clocks later; rx_valid=1, rx_data=A, rx_level=1.
  - drop STB -> ACK=0 at +3 clk.
  - rx_ready=1 -> rx_valid=0.
- CPU read:
  - local push 5 then C -> RDY=1, tx_level=2.
  - DIR=1, STB=1 -> pin_data=5 at +3, ACK at +4.
  - STB=0 -> bus z, ACK=0, tx_level=1.
  - second read -> C.
- RX full stall:
  - 8 CPU writes with no local pops -> rx_level=8.
  - 9th STB -> ACK stays 0.
  - one rx_ready pop -> ACK rises within 2 clk; 9th nibble stored at tail, rx_level=8.
- Read stall on empty: DIR=1, STB=1, TX empty -> no drive, ACK=0; push 3 -> pin_data=3, then ACK.
- Simultaneity and abort:
  - local push+pop on RX at level 4 in the same cycle -> level 4, FIFO order preserved.
  - assert rst_n=0 during RD_ACK -> ACK=0 and pin_data=z immediately; after release, state IDLE, levels 0.
